// File: rtl/mcycle_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding and
// MCycleOp bit positions.
package mcycle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      WB   = 2'd3
   } state_t;

   localparam int OP_DIV    = 0;
   localparam int OP_SIGNED = 1;

endpackage

// File: rtl/mcycle_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: stalls the pipeline,
// strobes load/step/sign-fix, then requests the register-file write port.
module mcycle_ctrl
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       M_Start,
   input  logic [1:0] MCycleOp,
   input  logic       MWrite,
   input  logic [3:0] MWA,
   input  logic       Operand2Zero,
   input  logic       Flush,
   input  logic       WbAck,
   output logic       Busy,
   output logic       Init,
   output logic       Step,
   output logic       FixSign,
   output logic       DivByZero,
   output logic       ResultWrite,
   output logic [3:0] ResultWA
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             mwrite_q, mwrite_d;
   logic [3:0]       mwa_q, mwa_d;
   logic             dbz_q, dbz_d;
   state_t           done_state;

   // A suppressed writeback skips WB entirely and frees the unit at once.
   assign done_state = mwrite_q ? WB : IDLE;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sgn_d    = sgn_q;
      mwrite_d = mwrite_q;
      mwa_d    = mwa_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE: begin
            if (M_Start) begin
               sgn_d    = MCycleOp[OP_SIGNED];
               mwrite_d = MWrite;
               mwa_d    = MWA;
               cnt_d    = '0;
               if (MCycleOp[OP_DIV] && Operand2Zero) begin
                  dbz_d   = MWrite;
                  state_d = MWrite ? WB : IDLE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (Flush) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = sgn_q ? FIX : done_state;
               end
            end
         end
         FIX: begin
            state_d = Flush ? IDLE : done_state;
         end
         WB: begin
            if (WbAck) begin
               state_d = IDLE;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sgn_q    <= 1'b0;
         mwrite_q <= 1'b0;
         mwa_q    <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sgn_q    <= sgn_d;
         mwrite_q <= mwrite_d;
         mwa_q    <= mwa_d;
         dbz_q    <= dbz_d;
      end
   end

   // Only Init and the IDLE half of Busy look at inputs; the rest is pure state.
   assign Init        = (state_q == IDLE) && M_Start;
   assign Busy        = (state_q != IDLE) || M_Start;
   assign Step        = (state_q == RUN);
   assign FixSign     = (state_q == FIX);
   assign ResultWrite = (state_q == WB);
   assign DivByZero   = dbz_q;
   assign ResultWA    = mwa_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Randomized bench for mcycle_ctrl against a timeline model: each operation is
// tracked by its cycle offset from the start and the phase is derived from it.
module tb_mcycle_ctrl;

   localparam int W = 32;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       M_Start;
   logic [1:0] MCycleOp;
   logic       MWrite;
   logic [3:0] MWA;
   logic       Operand2Zero;
   logic       Flush;
   logic       WbAck;
   logic       Busy, Init, Step, FixSign, DivByZero, ResultWrite;
   logic [3:0] ResultWA;

   int n_vec = 0;
   int n_err = 0;

   // Model of the operation in flight
   bit       m_active;
   int       m_k;
   bit       m_sgn, m_dbz, m_mw;
   bit [3:0] m_wa;

   mcycle_ctrl #(.WIDTH(W)) dut (
      .CLK(CLK), .RESET(RESET), .M_Start(M_Start), .MCycleOp(MCycleOp),
      .MWrite(MWrite), .MWA(MWA), .Operand2Zero(Operand2Zero), .Flush(Flush),
      .WbAck(WbAck), .Busy(Busy), .Init(Init), .Step(Step), .FixSign(FixSign),
      .DivByZero(DivByZero), .ResultWrite(ResultWrite), .ResultWA(ResultWA)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // First cycle offset at which the result is presented for writeback.
   function automatic int wb_start();
      return m_dbz ? 1 : (m_sgn ? W + 2 : W + 1);
   endfunction

   task automatic run_cycle(input bit st, input bit [1:0] op, input bit mw, input bit [3:0] wa,
                            input bit z, input bit fl, input bit ack, input bit rst);
      bit in_run, in_fix, in_wb;
      M_Start = st; MCycleOp = op; MWrite = mw; MWA = wa;
      Operand2Zero = z; Flush = fl; WbAck = ack; RESET = rst;
      #1;
      in_run = m_active && !m_dbz && m_k >= 1 && m_k <= W;
      in_fix = m_active && !m_dbz && m_sgn && m_k == W + 1;
      in_wb  = m_active && m_k >= wb_start();
      chk("Busy",        32'(Busy),        32'(m_active || st));
      chk("Init",        32'(Init),        32'(!m_active && st));
      chk("Step",        32'(Step),        32'(in_run));
      chk("FixSign",     32'(FixSign),     32'(in_fix));
      chk("ResultWrite", 32'(ResultWrite), 32'(in_wb));
      chk("DivByZero",   32'(DivByZero),   32'(m_active && m_dbz));
      chk("ResultWA",    32'(ResultWA),    32'(m_wa));
      if (rst) begin
         m_active = 1'b0;
         m_wa     = 4'd0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1'b1;
            m_k      = 1;
            m_sgn    = op[1];
            m_dbz    = op[0] && z;
            m_mw     = mw;
            m_wa     = wa;
            if (!m_mw && m_k >= wb_start()) m_active = 1'b0;
         end
      end else if ((in_run || in_fix) && fl) begin
         m_active = 1'b0;
      end else if (in_wb) begin
         if (ack) m_active = 1'b0;
      end else begin
         m_k++;
         if (!m_mw && m_k >= wb_start()) m_active = 1'b0;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      M_Start = 0; MCycleOp = 0; MWrite = 0; MWA = 0;
      Operand2Zero = 0; Flush = 0; WbAck = 0; RESET = 1;
      repeat (2) @(posedge CLK);
      #1;
      m_active = 0; m_k = 0; m_sgn = 0; m_dbz = 0; m_mw = 0; m_wa = 0;
      run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 1);

      // Unsigned multiply to register 5, ack always granted
      run_cycle(1, 2'b00, 1, 4'd5, 0, 0, 1, 0);
      repeat (35) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 1, 0);

      // Divide-by-zero, ack after two cycles
      run_cycle(1, 2'b01, 1, 4'd9, 1, 0, 0, 0);
      repeat (2) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);
      repeat (2) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 1, 0);

      // Signed divide with a repeated start in RUN, then reset while waiting in WB
      run_cycle(1, 2'b11, 1, 4'd12, 0, 0, 0, 0);
      repeat (4) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);
      run_cycle(1, 2'b00, 1, 4'd3, 0, 0, 0, 0);
      repeat (30) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);
      run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 1);
      repeat (2) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);

      // Flush at step 10, then restart with writeback suppressed
      run_cycle(1, 2'b10, 1, 4'd7, 0, 0, 0, 0);
      repeat (9) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);
      run_cycle(0, 2'b00, 0, 4'd0, 0, 1, 0, 0);
      run_cycle(1, 2'b00, 0, 4'd8, 0, 1, 0, 0);
      repeat (34) run_cycle(0, 2'b00, 0, 4'd0, 0, 0, 0, 0);

      for (int i = 0; i < 4000; i++) begin
         run_cycle($urandom_range(3) == 0, 2'($urandom), $urandom_range(3) != 0, 4'($urandom),
                   $urandom_range(3) == 0, $urandom_range(59) == 0, $urandom_range(1) == 0,
                   $urandom_range(399) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
